// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Data-memory responder for the MEM stage. Each 32-bit request is
//            carried out as two 16-bit accesses (low half, then high half) on
//            an external asynchronous SRAM. ready is held low until the
//            access finishes so the pipeline can freeze.
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller #(
   parameter int LEN           = 32,
   parameter int ADDR_BASE     = 1024,
   parameter int SRAM_ADDR_W   = 18,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   mem_r_en,
   input  logic                   mem_w_en,
   input  logic [LEN-1:0]         alu_result,
   input  logic [LEN-1:0]         st_value,
   output logic [LEN-1:0]         read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_we_n,
   output logic                   sram_oe_n
);

   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 state, state_next;
   logic [CNT_W-1:0]       count, count_next;
   logic                   op_write;
   logic [SRAM_ADDR_W-2:0] word_q;
   logic [LEN-1:0]         st_q;

   logic                   req;
   logic                   last;
   logic [LEN-1:0]         byte_off;
   logic [SRAM_ADDR_W-2:0] word;
   logic                   unused_bits;

   assign req      = mem_r_en | mem_w_en;
   assign last     = (count == CNT_W'(ACCESS_CYCLES - 1));
   // Word index wraps modulo the SRAM size; no range check is intended.
   assign byte_off = alu_result - LEN'(ADDR_BASE);
   assign word     = byte_off[SRAM_ADDR_W:2];
   // Byte-lane bits and address bits beyond the SRAM size are deliberately dropped.
   assign unused_bits = ^{byte_off[LEN-1:SRAM_ADDR_W+1], byte_off[1:0]};

   // Freeze must act in the same cycle the request appears, hence combinational.
   assign ready = ~req | (state == S_DONE);

   // State and per-half cycle counter register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Next-state logic: IDLE -> LOW -> HIGH -> DONE -> IDLE; a started access always completes.
   always_comb begin
      state_next = state;
      count_next = count;
      unique case (state)
         S_IDLE: begin
            if (req) begin
               state_next = S_LOW;
               count_next = '0;
            end
         end
         S_LOW: begin
            if (last) begin
               state_next = S_HIGH;
               count_next = '0;
            end else begin
               count_next = count + 1'b1;
            end
         end
         S_HIGH: begin
            if (last) begin
               state_next = S_DONE;
               count_next = '0;
            end else begin
               count_next = count + 1'b1;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Latch the operation when a request is accepted; a write wins if both enables are set.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_write <= 1'b0;
         word_q   <= '0;
         st_q     <= '0;
      end else if (state == S_IDLE && req) begin
         op_write <= mem_w_en;
         word_q   <= word;
         st_q     <= st_value;
      end
   end

   // Capture each read half on the last cycle of its access window.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         read_data <= '0;
      end else if (!op_write && last) begin
         if (state == S_LOW) begin
            read_data[15:0] <= sram_dq_in;
         end else if (state == S_HIGH) begin
            read_data[31:16] <= sram_dq_in;
         end
      end
   end

   // Moore decode of the SRAM strobes from state and the latched operation.
   always_comb begin
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      if (state == S_LOW || state == S_HIGH) begin
         sram_addr = {word_q, (state == S_HIGH)};
         if (op_write) begin
            sram_we_n   = 1'b0;
            sram_dq_oe  = 1'b1;
            sram_dq_out = (state == S_HIGH) ? st_q[31:16] : st_q[15:0];
         end else begin
            sram_oe_n = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
# sram_controller

Responder for the data-memory requests issued by the MEM stage of the 5-stage pipeline. It accepts one 32-bit read or write per request, splits it into two 16-bit accesses on an external asynchronous SRAM, and holds `ready` low until the access completes. While `ready` is low, the pipeline top must freeze all stage registers. The block replaces the single-cycle internal data memory and sits between the EXEMEM register outputs and the MEMWB register inputs.

## Interface
- `LEN`, 32, data and address width on the pipeline side.
- `ADDR_BASE`, 1024, byte address that maps to SRAM word 0.
- `SRAM_ADDR_W`, 18, SRAM address width, counted in 16-bit halfwords.
- `ACCESS_CYCLES`, 2, cycles spent on each 16-bit half. Must be ≥ 1.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_r_en`  in  1  read request, held by the pipeline until `ready`.
- `mem_w_en`  in  1  write request, held by the pipeline until `ready`.
- `alu_result`  in  LEN  byte address, word aligned.
- `st_value`  in  LEN  store data.
- `read_data`  out  LEN  registered read result.
- `ready`  out  1  request complete; 0 means freeze the pipeline.
- `sram_addr`  out  SRAM_ADDR_W  halfword address.
- `sram_dq_out`  out  16  write data.
- `sram_dq_oe`  out  1  drive enable for the data bus; the pad tristate lives at top level.
- `sram_dq_in`  in  16  read data from the pad.
- `sram_we_n`  out  1  active-low write enable.
- `sram_oe_n`  out  1  active-low output enable.

## Operation
- Request: `req = mem_r_en | mem_w_en`. If both are asserted, the request is a write.
- Address mapping: `word = (alu_result - ADDR_BASE) >> 2`, truncated to `SRAM_ADDR_W-1` bits. The result wraps modulo the SRAM size; there is no range check.
- Low half address is `{word, 1'b0}`; high half address is `{word, 1'b1}`.
- States:
  - IDLE: if `req`, latch the operation, address and `st_value`, then go to LOW with count = 0.
  - LOW: run for `ACCESS_CYCLES` cycles. On the last cycle of a read, capture `sram_dq_in` into `read_data[15:0]`. Then go to HIGH with count = 0.
  - HIGH: same as LOW for the upper half; a read captures into `read_data[31:16]`. Then go to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- SRAM drive is Moore, decoded from state and the latched operation:
  - LOW/HIGH write: `sram_we_n = 0`, `sram_oe_n = 1`, `sram_dq_oe = 1`, `sram_dq_out` = the selected half of the latched store data.
  - LOW/HIGH read: `sram_we_n = 1`, `sram_oe_n = 0`, `sram_dq_oe = 0`.
  - IDLE/DONE: `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
- `ready = ~req | (state == DONE)`. This is combinational, because the freeze must take effect in the same cycle the request appears.
- A transaction that has left IDLE always completes, even if `req` drops. Inputs are latched, so changes after IDLE are ignored.
- `read_data` keeps the last completed read value. Writes never modify it.

## Timing
- Reset (asynchronous, active-low) values:
  - State goes to IDLE; count = 0; `read_data` = 0; latched operands = 0.
  - SRAM outputs take their idle values.
  - `ready` = 1 when no request is present.
- Reset asserted mid-transaction aborts it immediately. The SRAM is left with whatever half was already written; there is no rollback.
- Latency, with the request first seen in cycle 0:
  - `ready` = 0 in cycles 0 .. 2·ACCESS_CYCLES.
  - `ready` = 1 in cycle 2·ACCESS_CYCLES+1 (cycle 5 at the default).
  - `read_data` is valid in that same cycle, which is the edge on which MEMWB samples.
- Back-to-back: if `req` is still high in the IDLE cycle after DONE, a new transaction starts. Each access occupies 2·ACCESS_CYCLES+2 cycles.
- The count width is `$clog2(ACCESS_CYCLES)`, minimum 1. At `ACCESS_CYCLES = 1`, each half occupies exactly one cycle.

## Test plan
- Write `alu_result = 1024`, `st_value = 0x12345678`:
  - SRAM sees `addr 0 / dq 0x5678 / we_n 0` in cycles 1–2, then `addr 1 / dq 0x1234` in cycles 3–4.
  - `ready` rises in cycle 5.
- Read `1024` after that write: `sram_oe_n = 0` in cycles 1–4, and `read_data = 0x12345678` with `ready = 1` in cycle 5.
- Write `1028` then read `1028` back-to-back: halves land at SRAM addresses 2 and 3, read returns the written data, and `read_data` of the earlier read stays unchanged during the write.
- `mem_r_en = mem_w_en = 1`, `st_value = 0xCAFEBABE`, `alu_result = 1032`: the block performs a write (addresses 4 and 5, `we_n` low) and `read_data` is unchanged.
- `reset` pulled low in cycle 2 of a write:
  - Same cycle: state IDLE, `sram_we_n = 1`, `sram_dq_oe = 0`, `read_data = 0`.
  - After release with no request: `ready = 1`.
- No request for 10 cycles: `ready` stays 1, all SRAM strobes stay inactive, and `sram_addr` stays 0.
